// File: rtl/karatsuba_sched.sv
// Two-requester 16x16 unsigned multiplier built from one shared 8x8 Karatsuba core, four passes per product.
// Define KARATSUBA_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module karatsuba_mul8 (
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] z
);
   logic [7:0] z0;
   logic [7:0] z2;
   logic [4:0] xs;
   logic [4:0] ys;
   logic [9:0] zm;
   logic [9:0] z1;

   assign z0 = {4'b0, x[3:0]} * {4'b0, y[3:0]};
   assign z2 = {4'b0, x[7:4]} * {4'b0, y[7:4]};
   assign xs = {1'b0, x[7:4]} + {1'b0, x[3:0]};
   assign ys = {1'b0, y[7:4]} + {1'b0, y[3:0]};
   assign zm = {5'b0, xs} * {5'b0, ys};
   // Middle term equals xh*yl + xl*yh, never negative, at most 450.
   assign z1 = zm - {2'b0, z2} - {2'b0, z0};
   assign z  = {z2, 8'b0} + {2'b0, z1, 4'b0} + {8'b0, z0};
endmodule

module karatsuba_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_p,
   output logic        res_id,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [1:0]  pass_reg;
   logic [31:0] acc_reg;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic        id_reg;
   logic        grant_id;
   logic        accept;
   logic [7:0]  mul_x;
   logic [7:0]  mul_y;
   logic [15:0] mul_z;
   logic [31:0] partial;

`ifdef KARATSUBA_SCHED_RR_EN
   logic        rr_ptr_reg;

   // On contention the pointer picks; it then points at the loser.
   assign grant_id = (req0_valid && req1_valid) ? rr_ptr_reg : req1_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= 1'b0;
      end else if (accept) begin
         rr_ptr_reg <= ~grant_id;
      end
   end
`else
   assign grant_id = req1_valid && !req0_valid;
`endif

   // Pass bit 0 selects the a half, bit 1 the b half.
   assign mul_x = pass_reg[0] ? a_reg[15:8] : a_reg[7:0];
   assign mul_y = pass_reg[1] ? b_reg[15:8] : b_reg[7:0];

   karatsuba_mul8 u_mul (
      .x (mul_x),
      .y (mul_y),
      .z (mul_z)
   );

   always_comb begin
      partial = {16'b0, mul_z};
      case (pass_reg)
         2'd0:    partial = {16'b0, mul_z};
         2'd1:    partial = {8'b0, mul_z, 8'b0};
         2'd2:    partial = {8'b0, mul_z, 8'b0};
         default: partial = {mul_z, 16'b0};
      endcase
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            req0_ready = req0_valid && !grant_id;
            req1_ready = req1_valid && grant_id;
            accept     = req0_valid || req1_valid;
            if (accept) begin
               state_next = MUL;
            end
         end
         MUL: begin
            if (pass_reg == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pass_reg  <= 2'd0;
         acc_reg   <= 32'd0;
         a_reg     <= 16'd0;
         b_reg     <= 16'd0;
         id_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg    <= grant_id ? req1_a : req0_a;
            b_reg    <= grant_id ? req1_b : req0_b;
            id_reg   <= grant_id;
            acc_reg  <= 32'd0;
            pass_reg <= 2'd0;
         end else if (state_reg == MUL) begin
            acc_reg  <= acc_reg + partial;
            pass_reg <= pass_reg + 2'd1;
         end
      end
   end

   assign res_valid = (state_reg == DONE);
   assign res_p     = acc_reg;
   assign res_id    = id_reg;
   assign busy      = (state_reg != IDLE);
endmodule

// File: doc/karatsuba_sched.md
KARATSUBA_SCHED -- requirements
Module: karatsuba_sched

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  block accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  16 each  requester 0 operands, unsigned.
REQ-007 req1_valid, req1_ready, req1_a, req1_b: same as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  product available.
REQ-009 res_ready  input  1  consumer accepts the product.
REQ-010 res_p  output  32  unsigned product a*b.
REQ-011 res_id  output  1  index of the requester that owns res_p.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block shall contain exactly one instance of the team's 8x8 karatsuba multiplier (X, Y in 8 bits, Z out 16 bits, combinational), time-shared across all passes and requesters.
REQ-014 FSM states: IDLE, MUL, DONE.
  - IDLE->MUL on an accept handshake.
  - MUL->DONE after pass 3.
  - DONE->IDLE on res_valid&res_ready.
REQ-015 Ready gating: reqN_ready=1 only in IDLE and only for the granted requester; it may depend combinationally on req0_valid/req1_valid.
REQ-016 Grant rules:
  - Only one requester valid: that requester is granted.
  - Both valid: the round-robin pointer decides.
  - After each accept, the pointer moves to the requester that was not granted.
REQ-017 On the accept edge, the block shall latch a, b and id, clear the 32-bit accumulator and set pass=0.
REQ-018 Pass schedule, one pass per clock in MUL:
  - pass 0: a[7:0]*b[7:0], shift 0.
  - pass 1: a[15:8]*b[7:0], shift 8.
  - pass 2: a[7:0]*b[15:8], shift 8.
  - pass 3: a[15:8]*b[15:8], shift 16.
  - Each pass adds its shifted partial product to the accumulator.
REQ-019 Accumulation is 32-bit unsigned with no truncation; the final value shall equal a*b exactly for all 16-bit inputs.
REQ-020 Latency: res_valid shall rise exactly 4 rising edges after the accept edge, with res_p = accumulator and res_id = latched id.
REQ-021 While res_valid=1 and res_ready=0, res_p and res_id shall hold stable and both reqN_ready shall be 0; no new accept is possible until the DONE->IDLE edge.
REQ-022 res_valid shall fall on the res handshake edge.
  - The earliest next accept is the cycle after that edge.
  - The next res_valid is therefore at least 6 cycles after the previous one.
REQ-023 reqN_valid changes during MUL/DONE shall be ignored; latched operands are unaffected by input changes after the accept.
REQ-024 busy = (state != IDLE).

Reset
REQ-025 While rst_n=0, asynchronously:
  - state=IDLE, pass=0, accumulator=0.
  - res_valid=0, res_p=0, res_id=0.
  - round-robin pointer prefers requester 0.
  - req0_ready and req1_ready follow REQ-015 from IDLE.
REQ-026 Reset asserted in MUL or DONE shall discard the transaction; no res_valid shall be produced for it after release.
REQ-027 The first rising edge after rst_n deasserts may accept a request.

Configuration
REQ-028 Macro KARATSUBA_SCHED_RR_EN selects the arbitration policy.
  - Defined: round-robin per REQ-016.
  - Undefined: fixed priority, requester 0 always wins when both are valid, and no pointer register is implemented.
  - All other behaviour shall be identical in both builds.

Verification
REQ-029 req0 a=0xFFFF b=0xFFFF, res_ready=1 -> res_valid 4 edges after accept, res_p=0xFFFE0001, res_id=0.
REQ-030 req1 a=0x1234 b=0x5678 -> res_p=0x06260060, res_id=1; a=0x0000 b=0xABCD -> res_p=0x00000000.
REQ-031 Both requesters valid continuously for 4 transactions, with macro -> res_id sequence 0,1,0,1; without macro -> 0,0,0,0.
REQ-032 res_ready=0 for 10 cycles after res_valid -> res_p/res_id stable, req0_ready=req1_ready=0, busy=1; then res_ready=1 -> IDLE on the next edge.
REQ-033 rst_n pulsed low during pass 2 -> all outputs at reset values immediately, no res_valid after release; a new request then completes normally.
REQ-034 Random 16-bit operands, 1000 transactions, random valid/res_ready -> every res_p = a*b, with ids matching the accept order.
